// File: rtl/sfla40_16x8bw16_pkg.sv
// Shared constants, command enum and priority decode for the sfla40 ternary CAM.
package sfla40_pkg;

  localparam int SFLA40_BITS         = 8;
  localparam int SFLA40_WORDS        = 16;
  localparam int SFLA40_ADDRESS_SIZE = 4;
  localparam int SFLA40_BANK_SIZE    = 1;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_FLUSH,
    CMD_WRITE,
    CMD_READ,
    CMD_COMPARE
  } cmd_e;

  // Only the highest-priority request survives: FLUSH > WR > RD > CMP.
  function automatic cmd_e decode_cmd(input logic en, input logic flush,
                                      input logic wr, input logic rd,
                                      input logic cmp);
    cmd_e cmd;
    cmd = CMD_NOP;
    if (en) begin
      if (flush)    cmd = CMD_FLUSH;
      else if (wr)  cmd = CMD_WRITE;
      else if (rd)  cmd = CMD_READ;
      else if (cmp) cmd = CMD_COMPARE;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/sfla40_16x8bw16_if.sv
// Command/data bus between the routing controller (master) and the CAM (slave).
interface sfla40_16x8bw16_if
  import sfla40_pkg::*;
#(
  parameter int Bits        = SFLA40_BITS,
  parameter int Words       = SFLA40_WORDS,
  parameter int AddressSize = SFLA40_ADDRESS_SIZE,
  parameter int BankSize    = SFLA40_BANK_SIZE
);

  logic                   CS;
  logic                   FLUSH;
  logic                   WR;
  logic                   RD;
  logic                   CMP;
  logic                   VBE;
  logic                   DCS;
  logic [Bits-1:0]        DI;
  logic [Bits-1:0]        MSKB;
  logic                   VBI;
  logic [AddressSize-1:0] A;
  logic [BankSize-1:0]    CBE;
  logic [Bits-1:0]        DO;
  logic                   VBO;
  logic                   HIT;
  logic [Words-1:0]       HITLINE;

  modport master (
    output CS, FLUSH, WR, RD, CMP, VBE, DCS, DI, MSKB, VBI, A, CBE,
    input  DO, VBO, HIT, HITLINE
  );

  modport slave (
    input  CS, FLUSH, WR, RD, CMP, VBE, DCS, DI, MSKB, VBI, A, CBE,
    output DO, VBO, HIT, HITLINE
  );

endinterface

// File: rtl/sfla40_16x8bw16_match_line.sv
// Combinational ternary comparator for one CAM entry.
module sfla40_match_line #(
  parameter int Bits = 8
) (
  input  logic [Bits-1:0] key,
  input  logic [Bits-1:0] mask,
  input  logic [Bits-1:0] data,
  input  logic [Bits-1:0] care,
  input  logic            valid,
  output logic            match
);

  // A bit agrees if the key ignores it, the entry ignores it, or the values are equal.
  assign match = valid & (&(~mask | ~care | ~(key ^ data)));

endmodule

// File: rtl/sfla40_16x8bw16.sv
// 16x8 ternary CAM with masked write, read, parallel compare and flush.
// Define SFLA40_ASSERT_EN to compile in simulation assertions on the command bus.
module sfla40_16x8bw16
  import sfla40_pkg::*;
#(
  parameter int Bits        = SFLA40_BITS,
  parameter int Words       = SFLA40_WORDS,
  parameter int AddressSize = SFLA40_ADDRESS_SIZE,
  parameter int BankSize    = SFLA40_BANK_SIZE
) (
  input logic               CK,
  input logic               RST,
  sfla40_16x8bw16_if.slave  bus
);

  logic [Bits-1:0]  data_q [Words];
  logic [Bits-1:0]  care_q [Words];
  logic [Words-1:0] valid_q;

  logic [Bits-1:0]  do_q;
  logic             vbo_q;
  logic             hit_q;
  logic [Words-1:0] hitline_q;

  cmd_e             cmd;
  logic             addr_ok;
  logic [Words-1:0] match_c;

  assign addr_ok = (32'(bus.A) < Words);

  always_comb begin
    cmd = decode_cmd(bus.CS & ~(|bus.CBE), bus.FLUSH, bus.WR, bus.RD, bus.CMP);
  end

  for (genvar i = 0; i < Words; i++) begin : g_match
    sfla40_match_line #(.Bits(Bits)) u_match (
      .key   (bus.DI),
      .mask  (bus.MSKB),
      .data  (data_q[i]),
      .care  (care_q[i]),
      .valid (valid_q[i]),
      .match (match_c[i])
    );
  end

  // Outputs not touched by the executed command keep their last value.
  always_ff @(posedge CK) begin
    if (RST) begin
      for (int i = 0; i < Words; i++) begin
        data_q[i] <= '0;
        care_q[i] <= '1;
      end
      valid_q   <= '0;
      do_q      <= '0;
      vbo_q     <= 1'b0;
      hit_q     <= 1'b0;
      hitline_q <= '0;
    end else begin
      case (cmd)
        CMD_FLUSH: begin
          valid_q   <= '0;
          hit_q     <= 1'b0;
          hitline_q <= '0;
        end
        CMD_WRITE: begin
          if (addr_ok) begin
            if (bus.DCS)
              data_q[bus.A] <= (data_q[bus.A] & ~bus.MSKB) | (bus.DI & bus.MSKB);
            else
              care_q[bus.A] <= (care_q[bus.A] & ~bus.MSKB) | (bus.DI & bus.MSKB);
            if (bus.VBE)
              valid_q[bus.A] <= bus.VBI;
          end
        end
        CMD_READ: begin
          if (addr_ok) begin
            do_q  <= bus.DCS ? data_q[bus.A] : care_q[bus.A];
            vbo_q <= bus.VBE & valid_q[bus.A];
          end else begin
            do_q  <= '0;
            vbo_q <= 1'b0;
          end
        end
        CMD_COMPARE: begin
          hitline_q <= match_c;
          hit_q     <= |match_c;
        end
        default: ;
      endcase
    end
  end

  assign bus.DO      = do_q;
  assign bus.VBO     = vbo_q;
  assign bus.HIT     = hit_q;
  assign bus.HITLINE = hitline_q;

`ifdef SFLA40_ASSERT_EN
  always @(posedge CK) begin
    if (!RST && bus.CS === 1'b1) begin
      assert (!$isunknown({bus.FLUSH, bus.WR, bus.RD, bus.CMP, bus.VBE, bus.DCS, bus.VBI, bus.CBE}));
      assert ($onehot0({bus.FLUSH, bus.WR, bus.RD, bus.CMP}));
      if (cmd == CMD_WRITE || cmd == CMD_READ)
        assert (addr_ok);
    end
  end
`endif

endmodule

// File: tb/tb_sfla40_16x8bw16.sv
// Directed self-checking bench for the sfla40_16x8bw16 ternary CAM.
module tb_sfla40_16x8bw16;

  logic CK;
  logic RST;
  int   num_checks;
  int   num_failures;

  sfla40_16x8bw16_if bus_if ();

  sfla40_16x8bw16 dut (
    .CK  (CK),
    .RST (RST),
    .bus (bus_if.slave)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Drives one command for a single cycle and returns #1 after the sampling edge.
  task automatic applyStimulus(input logic cs, input logic cbe, input logic flush,
                               input logic wr, input logic rd, input logic cmp,
                               input logic [3:0] a, input logic dcs,
                               input logic [7:0] di, input logic [7:0] mskb,
                               input logic vbe, input logic vbi);
    bus_if.CS    = cs;
    bus_if.CBE   = cbe;
    bus_if.FLUSH = flush;
    bus_if.WR    = wr;
    bus_if.RD    = rd;
    bus_if.CMP   = cmp;
    bus_if.A     = a;
    bus_if.DCS   = dcs;
    bus_if.DI    = di;
    bus_if.MSKB  = mskb;
    bus_if.VBE   = vbe;
    bus_if.VBI   = vbi;
    @(posedge CK);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic dcs, input logic [7:0] di,
                          input logic [7:0] mskb, input logic vbe, input logic vbi);
    applyStimulus(1, 0, 0, 1, 0, 0, a, dcs, di, mskb, vbe, vbi);
  endtask

  task automatic do_read(input logic [3:0] a, input logic dcs, input logic vbe);
    applyStimulus(1, 0, 0, 0, 1, 0, a, dcs, 8'h00, 8'h00, vbe, 0);
  endtask

  task automatic do_cmp(input logic [7:0] di, input logic [7:0] mskb);
    applyStimulus(1, 0, 0, 0, 0, 1, 4'd0, 0, di, mskb, 0, 0);
  endtask

  task automatic do_idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 4'd0, 0, 8'h00, 8'h00, 0, 0);
  endtask

  initial begin
    num_checks   = 0;
    num_failures = 0;
    RST = 1'b1;
    do_idle();
    do_idle();
    checkOutput("reset_do", 32'(bus_if.DO), 32'h00);
    checkOutput("reset_vbo", 32'(bus_if.VBO), 32'h0);
    checkOutput("reset_hit", 32'(bus_if.HIT), 32'h0);
    checkOutput("reset_hitline", 32'(bus_if.HITLINE), 32'h0000);
    RST = 1'b0;

    do_read(4'd3, 1, 1);
    checkOutput("rd3_data_do", 32'(bus_if.DO), 32'h00);
    checkOutput("rd3_data_vbo", 32'(bus_if.VBO), 32'h0);
    do_read(4'd3, 0, 1);
    checkOutput("rd3_care_do", 32'(bus_if.DO), 32'hFF);

    do_write(4'd5, 1, 8'hA5, 8'hFF, 1, 1);
    do_read(4'd5, 1, 1);
    checkOutput("rd5_do", 32'(bus_if.DO), 32'hA5);
    checkOutput("rd5_vbo", 32'(bus_if.VBO), 32'h1);
    do_write(4'd5, 1, 8'h00, 8'h0F, 0, 0);
    do_read(4'd5, 1, 0);
    checkOutput("rd5_masked_do", 32'(bus_if.DO), 32'hA0);
    checkOutput("rd5_vbe0_vbo", 32'(bus_if.VBO), 32'h0);
    do_read(4'd5, 0, 1);
    checkOutput("rd5_care_do", 32'(bus_if.DO), 32'hFF);
    checkOutput("rd5_care_vbo", 32'(bus_if.VBO), 32'h1);

    do_write(4'd2, 1, 8'h30, 8'hFF, 1, 1);
    do_cmp(8'h30, 8'hF0);
    checkOutput("cmp30_hit", 32'(bus_if.HIT), 32'h1);
    checkOutput("cmp30_hitline", 32'(bus_if.HITLINE), 32'h0004);
    checkOutput("cmp_hold_do", 32'(bus_if.DO), 32'hFF);
    checkOutput("cmp_hold_vbo", 32'(bus_if.VBO), 32'h1);
    do_cmp(8'h40, 8'hF0);
    checkOutput("cmp40_hit", 32'(bus_if.HIT), 32'h0);
    checkOutput("cmp40_hitline", 32'(bus_if.HITLINE), 32'h0000);

    do_write(4'd7, 1, 8'h5A, 8'hFF, 1, 1);
    do_write(4'd7, 0, 8'h0F, 8'hFF, 0, 0);
    do_cmp(8'hFA, 8'hFF);
    checkOutput("tern_hit", 32'(bus_if.HIT), 32'h1);
    checkOutput("tern_hitline", 32'(bus_if.HITLINE), 32'h0080);
    do_read(4'd7, 0, 1);
    checkOutput("rd7_care_do", 32'(bus_if.DO), 32'h0F);
    checkOutput("rd_hold_hitline", 32'(bus_if.HITLINE), 32'h0080);
    do_cmp(8'h00, 8'h00);
    checkOutput("nomask_hitline", 32'(bus_if.HITLINE), 32'h00A4);

    applyStimulus(1, 0, 1, 0, 0, 0, 4'd0, 0, 8'h00, 8'h00, 0, 0);
    checkOutput("flush_hit", 32'(bus_if.HIT), 32'h0);
    checkOutput("flush_hitline", 32'(bus_if.HITLINE), 32'h0000);
    do_read(4'd2, 1, 1);
    checkOutput("flush_rd2_do", 32'(bus_if.DO), 32'h30);
    checkOutput("flush_rd2_vbo", 32'(bus_if.VBO), 32'h0);
    do_cmp(8'h00, 8'h00);
    checkOutput("flush_cmp_hitline", 32'(bus_if.HITLINE), 32'h0000);

    do_write(4'd2, 1, 8'h00, 8'h00, 1, 1);
    do_cmp(8'h30, 8'hF0);
    checkOutput("revalid_hitline", 32'(bus_if.HITLINE), 32'h0004);
    do_read(4'd2, 1, 1);
    checkOutput("revalid_do", 32'(bus_if.DO), 32'h30);
    applyStimulus(1, 0, 0, 1, 1, 1, 4'd9, 1, 8'h3C, 8'hFF, 1, 1);
    checkOutput("prio_do", 32'(bus_if.DO), 32'h30);
    checkOutput("prio_vbo", 32'(bus_if.VBO), 32'h1);
    checkOutput("prio_hit", 32'(bus_if.HIT), 32'h1);
    checkOutput("prio_hitline", 32'(bus_if.HITLINE), 32'h0004);
    do_read(4'd9, 1, 1);
    checkOutput("prio_wr_do", 32'(bus_if.DO), 32'h3C);
    checkOutput("prio_wr_vbo", 32'(bus_if.VBO), 32'h1);

    applyStimulus(1, 0, 1, 1, 0, 0, 4'd4, 1, 8'h77, 8'hFF, 1, 1);
    do_read(4'd4, 1, 1);
    checkOutput("flushwr_rd4_do", 32'(bus_if.DO), 32'h00);
    checkOutput("flushwr_rd4_vbo", 32'(bus_if.VBO), 32'h0);
    do_read(4'd9, 1, 1);
    checkOutput("flushwr_rd9_do", 32'(bus_if.DO), 32'h3C);
    checkOutput("flushwr_rd9_vbo", 32'(bus_if.VBO), 32'h0);

    applyStimulus(0, 0, 0, 1, 0, 0, 4'd6, 1, 8'h99, 8'hFF, 1, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 4'd6, 1, 8'h00, 8'h00, 1, 0);
    checkOutput("cs0_rd_hold_do", 32'(bus_if.DO), 32'h3C);
    applyStimulus(1, 1, 0, 1, 0, 0, 4'd6, 1, 8'h99, 8'hFF, 1, 1);
    do_read(4'd6, 1, 1);
    checkOutput("gate_rd6_do", 32'(bus_if.DO), 32'h00);
    checkOutput("gate_rd6_vbo", 32'(bus_if.VBO), 32'h0);

    do_write(4'd1, 1, 8'hE7, 8'hFF, 1, 1);
    do_cmp(8'h00, 8'h00);
    checkOutput("pre_rst_hitline", 32'(bus_if.HITLINE), 32'h0002);
    RST = 1'b1;
    applyStimulus(1, 0, 0, 1, 0, 0, 4'd1, 1, 8'hFF, 8'hFF, 1, 1);
    RST = 1'b0;
    checkOutput("midrst_hit", 32'(bus_if.HIT), 32'h0);
    checkOutput("midrst_hitline", 32'(bus_if.HITLINE), 32'h0000);
    do_read(4'd1, 1, 1);
    checkOutput("midrst_rd1_do", 32'(bus_if.DO), 32'h00);
    checkOutput("midrst_rd1_vbo", 32'(bus_if.VBO), 32'h0);
    do_read(4'd1, 0, 1);
    checkOutput("midrst_rd1_care", 32'(bus_if.DO), 32'hFF);
    do_read(4'd9, 1, 1);
    checkOutput("midrst_rd9_do", 32'(bus_if.DO), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_failures);
    $finish;
  end

endmodule

// File: doc/sfla40_16x8bw16.md
# sfla40_16x8bw16

Synchronous ternary CAM macro model: 16 entries of 8 data bits, each with an 8-bit care mask and a valid bit. It supports bit-masked write, read, parallel compare and single-cycle flush. It sits under the packet-routing memory controller, which drives one command per cycle and priority-encodes `HITLINE` into a follow-up read address.

## Interface
Parameters:
- `Bits`, 8, word width
- `Words`, 16, entry count
- `AddressSize`, 4, address width (must satisfy 2^AddressSize >= Words)
- `BankSize`, 1, width of bank-enable vector

Ports:
- `CK` in 1: single clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `CS` in 1: chip select; 0 = no operation, all outputs hold.
- `FLUSH` in 1: invalidate all entries.
- `WR` in 1: write command.
- `RD` in 1: read command.
- `CMP` in 1: compare command.
- `VBE` in 1: valid-bit enable for write/read.
- `DCS` in 1: array select; 1 = data array, 0 = care array.
- `DI` in Bits: write data / compare key.
- `MSKB` in Bits: active-low mask.
  - Write: 1 = bit written.
  - Compare: 1 = bit compared.
- `VBI` in 1: valid bit to write.
- `A` in AddressSize: entry address.
- `CBE` in BankSize: active-low bank enable; any bit 1 = command ignored.
- `DO` out Bits: read data.
- `VBO` out 1: read valid bit.
- `HIT` out 1: any entry matched the last compare.
- `HITLINE` out Words: per-entry match vector of the last compare.

## Operation
- Storage per entry i:
  - `data[i]`, reset 0.
  - `care[i]`, reset all-ones.
  - `valid[i]`, reset 0.
- Reset: `RST`=1 at a clock edge has highest priority and overrides `CS`.
  - Reinitialises all storage.
  - Clears `DO`, `VBO`, `HIT` and `HITLINE` to 0.
- Gating: commands execute only when `CS`=1 and `CBE`=0.
- Command priority when several are asserted: FLUSH > WR > RD > CMP. Only the highest-priority command executes.
- FLUSH:
  - Clears all `valid` bits; data and care arrays are kept.
  - Clears `HIT` and `HITLINE`.
- WR, for each bit b with `MSKB[b]`=1:
  - `DCS`=1: `data[A][b]` <= `DI[b]`.
  - `DCS`=0: `care[A][b]` <= `DI[b]`.
  - If `VBE`=1, `valid[A]` <= `VBI`.
- RD:
  - `DO` <= `DCS` ? `data[A]` : `care[A]`.
  - `VBO` <= `VBE` ? `valid[A]` : 0.
- CMP:
  - Match condition: `HITLINE[i]` <= `valid[i]` & AND over all bits b of (!`MSKB[b]` | !`care[i][b]` | (`DI[b]`==`data[i][b]`)).
  - `HIT` <= OR of all `HITLINE` bits.
  - `A`, `VBE`, `DCS` and `VBI` are ignored.
- Address out of range (`A` >= Words): writes are dropped; reads return `DO`=0, `VBO`=0.
- Outputs not updated by a command hold their previous value:
  - `DO`/`VBO` hold across CMP.
  - `HIT`/`HITLINE` hold across WR and RD; they are not recomputed when entries change.

## Timing
- All state and outputs are registered on the `CK` rising edge.
- Read latency is 1: `DO`/`VBO` are valid after the edge that samples RD.
- Compare latency is 1: `HIT`/`HITLINE` are valid after the edge that samples CMP.
  - The controller may encode `HITLINE` combinationally and issue RD on the next cycle.
- Write is visible to a RD or CMP in the next cycle. No same-cycle forwarding is needed, since only one command executes per cycle.
- Throughput is one command per cycle with back-to-back commands allowed. There is no handshake.
- Reset asserted mid-sequence takes effect at that edge, and any command in the same cycle is discarded.

## Configuration
- Macro `SFLA40_ASSERT_EN`.
- When defined, simulation assertions are compiled in and flag:
  - more than one of FLUSH/WR/RD/CMP asserted with `CS`=1;
  - `A` >= Words on WR/RD;
  - X on any control input while `CS`=1.
- When undefined, no assertions are compiled. Functional behaviour is identical either way.

## Structure
- Package `sfla40_pkg` holds:
  - default parameter constants (Bits, Words, AddressSize, BankSize);
  - the enum for the decoded command (NOP, FLUSH, WRITE, READ, COMPARE);
  - the priority-decode function.
- Sub-module `sfla40_match_line` is the combinational per-entry ternary comparator: inputs key, global mask, entry data, care and valid; output match. It is instantiated Words times.
- The top holds the storage arrays, command decode and output registers.

## Test plan
- Reset, then RD `A`=3 with `DCS`=1, `VBE`=1 → `DO`=0x00, `VBO`=0. Then RD with `DCS`=0 → `DO`=0xFF.
- WR `A`=5, `DCS`=1, `DI`=0xA5, `MSKB`=0xFF, `VBE`=1, `VBI`=1. Then RD `A`=5 → `DO`=0xA5, `VBO`=1.
  - WR `DI`=0x00, `MSKB`=0x0F. Then RD → `DO`=0xA0.
- Store entry 2 = 0x30 valid. CMP `DI`=0x30, `MSKB`=0xF0 → `HIT`=1, `HITLINE`=0x0004.
  - CMP `DI`=0x40 → `HIT`=0, `HITLINE`=0.
- Ternary: entry 7 data 0x5A, care 0x0F, valid. CMP `DI`=0xFA, `MSKB`=0xFF → `HITLINE[7]`=1.
- FLUSH after a hit → `HIT`=0, `HITLINE`=0. Then RD of entry 2 → `VBO`=0 and data 0x30 retained.
- Priority and gating:
  - WR+RD+CMP together → only the write occurs; `DO` and `HIT` are unchanged.
  - `CS`=0 or `CBE`=1 with WR → no storage change.
